// File: rtl/mult_arbiter.sv
// Two-way round-robin sequencer for a shared 5x5 signed multiplier.
// Optional overflow flag output is enabled with `define MULT_ARB_OVF_EN.

module signed_mult (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [9:0] p
);
    logic [4:0] mag_a;
    logic [4:0] mag_b;
    logic [7:0] mag_p;
    logic       neg;

    // Sign plus 8-bit magnitude: only |-16 * -16| = 256 falls outside it.
    assign mag_a = a[4] ? 5'(-a) : a;
    assign mag_b = b[4] ? 5'(-b) : b;
    assign mag_p = 8'(mag_a * mag_b);
    assign neg   = a[4] ^ b[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (start) begin
            p <= neg ? 10'(-{2'b00, mag_p}) : {2'b00, mag_p};
        end
    end
endmodule

module mult_arbiter #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [4:0] a0,
    input  logic [4:0] b0,
    output logic       ack0,
    output logic       done0,
    input  logic       req1,
    input  logic [4:0] a1,
    input  logic [4:0] b1,
    output logic       ack1,
    output logic       done1,
    output logic [9:0] result,
    output logic       busy
`ifdef MULT_ARB_OVF_EN
    ,
    output logic       ovf
`endif
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       gnt;
    logic       last;
    logic       sel;
    logic       start;
    logic [4:0] op_a;
    logic [4:0] op_b;
    logic [9:0] mult_p;

    // On a tie the requester that did not go last wins.
    assign sel = (req0 && req1) ? ~last : req1;

    assign start = (state == ST_START);
    assign busy  = (state != ST_IDLE);
    assign ack0  = start && !gnt;
    assign ack1  = start && gnt;
    assign done0 = (state == ST_DONE) && !gnt;
    assign done1 = (state == ST_DONE) && gnt;

    signed_mult u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .p     (mult_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            gnt    <= 1'b0;
            last   <= 1'b1;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
`ifdef MULT_ARB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt   <= sel;
                        op_a  <= sel ? a1 : a0;
                        op_b  <= sel ? b1 : b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= 4'(SETTLE - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        result <= mult_p;
`ifdef MULT_ARB_OVF_EN
                        ovf    <= (op_a == 5'b10000) && (op_b == 5'b10000);
`endif
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    last  <= gnt;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
